serial_frame_rx: RTL

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_pkg.sv | 19 +
 rtl/sipo_shift.sv | 19 +
 rtl/serial_frame_rx.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Optional parity support is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
package serial_frame_pkg;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  localparam int DATA_W_DEF    = 8;
  localparam int FRAME_LEN     = 1 + DATA_W_DEF;
  localparam int FRAME_LEN_PAR = 2 + DATA_W_DEF;

  function automatic int frame_len(input int dw, input bit par);
    return 1 + dw + (par ? 1 : 0);
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out register: new bits enter at the LSB, clear has priority.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      q <= '0;
    else if (clr)      q <= '0;
    else if (shift_en) q <= {q[W-2:0], sin};
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Start-bit framed serial receiver with a single-entry holding register.
// Define SERIAL_FRAME_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sdi,
  output logic [DATA_W-1:0] pdata,
  output logic              pvalid,
  input  logic              pready,
  output logic              busy,
  output logic              overrun,
  output logic              perr
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sr_q, frame;
  logic              sr_clr, sr_en, last_data, done, frame_ok;
  logic              accept, load;

  sipo_shift #(.W(DATA_W)) u_sipo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (sr_clr),
    .shift_en (sr_en),
    .sin      (sdi),
    .q        (sr_q)
  );

  assign last_data = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sr_clr    = 1'b0;
    sr_en     = 1'b0;
    done      = 1'b0;
    frame_ok  = 1'b1;
    frame     = sr_q;
    case (state)
      IDLE: begin
        if (sdi) begin
          state_nxt = DATA;
          sr_clr    = 1'b1;
        end
      end
      DATA: begin
        sr_en = 1'b1;
        if (last_data) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          state_nxt = PARITY;
`else
          // Final data bit is still on sdi: build the frame around it.
          state_nxt = IDLE;
          done      = 1'b1;
          frame     = {sr_q[DATA_W-2:0], sdi};
`endif
        end
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
        done      = 1'b1;
        frame_ok  = ~(^{sr_q, sdi});
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (state == DATA) cnt <= cnt + 1'b1;
    else                    cnt <= '0;
  end

  // A frame may land in the holding register on the same edge it is drained.
  assign accept = done && frame_ok;
  assign load   = accept && (!pvalid || pready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pdata   <= '0;
      pvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) pdata <= frame;
      pvalid  <= load || (pvalid && !pready);
      overrun <= accept && pvalid && !pready;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr <= 1'b0;
    else          perr <= done && !frame_ok;
  end
`else
  assign perr = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
